// File: rtl/multicycle_control_unit.sv
// Multi-cycle fetch/decode/exec/writeback controller: owns the PC, fetches over
// a req/ack handshake and drives register-bank, ALU and stack controls.
module multicycle_control_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    input  logic            zero,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic [31:0]     imm,
    output logic            reg_write,
    output logic            nop,
    output logic [1:0]      stack_op,
    output logic            jal,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     retired,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_PUSH  = 6'b111000;
    localparam logic [5:0] OP_POP   = 6'b111001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [31:0]     r_retired;

    logic [5:0]      w_op;
    logic            w_is_r;
    logic            w_is_addi;
    logic            w_is_beq;
    logic            w_is_j;
    logic            w_is_jal;
    logic            w_is_push;
    logic            w_is_pop;
    logic            w_is_halt;
    logic            w_fetch;
    logic [PC_W-1:0] w_br_off;
    logic [PC_W-1:0] w_jmp_tgt;

    // Decode straight from the latched IR; an all-zero IR is R-type shaped but is a NOP.
    assign w_op      = r_ir[31:26];
    assign w_is_r    = (w_op == OP_RTYPE) && (r_ir != 32'd0);
    assign w_is_addi = (w_op == OP_ADDI);
    assign w_is_beq  = (w_op == OP_BEQ);
    assign w_is_j    = (w_op == OP_J);
    assign w_is_jal  = (w_op == OP_JAL);
    assign w_is_push = (w_op == OP_PUSH);
    assign w_is_pop  = (w_op == OP_POP);
    assign w_is_halt = (w_op == OP_HALT);

    assign rs          = r_ir[25:21];
    assign rt          = r_ir[20:16];
    assign rd          = r_ir[15:11];
    assign imm         = {{16{r_ir[15]}}, r_ir[15:0]};
    assign alu_src_imm = w_is_addi;
    assign nop         = !(w_is_r || w_is_addi || w_is_beq || w_is_j || w_is_jal ||
                           w_is_push || w_is_pop || w_is_halt);

    // Branch offset is imm in words; jump target keeps the upper PC nibble of pc+4.
    assign w_br_off  = {{(PC_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
    assign w_jmp_tgt = {r_pc[PC_W-1:28], r_ir[25:0], 2'b00};

    always_comb begin
        alu_op = 4'b0000;
        if (w_is_r)
            alu_op = r_ir[3:0];
        else if (w_is_addi)
            alu_op = 4'b0010;
        else if (w_is_beq)
            alu_op = 4'b0110;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        reg_write   = 1'b0;
        jal         = 1'b0;
        stack_op    = 2'b00;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_fetch = 1'b1;
                if (imem_ack)
                    w_state_nxt = S_DECODE;
            end
            S_DECODE: w_state_nxt = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB: begin
                reg_write   = w_is_r || w_is_addi || w_is_pop || w_is_jal;
                jal         = w_is_jal;
                stack_op    = w_is_push ? 2'b01 : (w_is_pop ? 2'b10 : 2'b00);
                w_state_nxt = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // Gating with reset drops the request in the same cycle reset is asserted.
    assign imem_req  = w_fetch && !reset;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign retired   = r_retired;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_FETCH && imem_ack) begin
                r_ir <= imem_data;
                r_pc <= r_pc + PC_W'(4);
            end
            if (r_state == S_EXEC) begin
                if (w_is_beq && zero)
                    r_pc <= r_pc + w_br_off;
                else if (w_is_j || w_is_jal)
                    r_pc <= w_jmp_tgt;
            end
            if (r_state == S_WB)
                r_retired <= r_retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an imem responder issues random instructions, a reference
// model predicts each retirement, and a monitor checks the DUT on every retire.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic        zero = 1'b0;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic        reg_write;
    logic        nop;
    logic [1:0]  stack_op;
    logic        jal;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;

    multicycle_control_unit #(.PC_W(32), .RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .zero(zero), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .imm(imm), .reg_write(reg_write), .nop(nop), .stack_op(stack_op), .jal(jal),
        .pc(pc), .retired(retired), .halted(halted)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] npc;
        bit          rw;
        bit          jl;
        logic [1:0]  stk;
        bit          nop;
        bit          halt;
        bit          chk_alu;
        logic [3:0]  alu;
        bit          src;
        int          wb_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   run   = 0;
    bit   abort = 0;
    logic [31:0] mpc = 32'd0;
    int   n_ret = 0;
    logic [5:0] ill_ops [6] = '{6'h01, 6'h05, 6'h0C, 6'h23, 6'h2B, 6'h3A};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what one instruction at address a must do, from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic z, input logic [31:0] a);
        exp_t        e;
        logic [31:0] p4;
        logic [5:0]  op;
        p4 = a + 32'd4;
        op = ins[31:26];
        e.ins = ins; e.npc = p4; e.rw = 0; e.jl = 0; e.stk = 2'b00; e.nop = 0;
        e.halt = 0; e.chk_alu = 0; e.alu = 4'd0; e.src = 0; e.wb_cyc = 0;
        case (op)
            6'h00: if (ins != 32'd0) begin
                       e.rw = 1; e.chk_alu = 1; e.alu = ins[3:0];
                   end else e.nop = 1;
            6'h08: begin e.rw = 1; e.chk_alu = 1; e.alu = 4'd2; e.src = 1; end
            6'h04: begin
                       e.chk_alu = 1; e.alu = 4'd6;
                       if (z) e.npc = p4 + 32'(int'($signed(ins[15:0])) * 4);
                   end
            6'h02: e.npc = (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
            6'h03: begin
                       e.npc = (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 4);
                       e.rw = 1; e.jl = 1;
                   end
            6'h38: e.stk = 2'b01;
            6'h39: begin e.stk = 2'b10; e.rw = 1; end
            6'h3F: e.halt = 1;
            default: e.nop = 1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: begin r[31:26] = 6'h00; if (r == 32'd0) r = 32'h20; end
            1: r[31:26] = 6'h08;
            2: r[31:26] = 6'h04;
            3: r[31:26] = 6'h02;
            4: r[31:26] = 6'h03;
            5: r[31:26] = 6'h38;
            6: r[31:26] = 6'h39;
            7: r = 32'd0;
            default: r[31:26] = ill_ops[$urandom_range(0, 5)];
        endcase
        return r;
    endfunction

    // Serve one fetch: spurious acks while req is low, dly wait cycles, then ack.
    task automatic fetch_one(input logic [31:0] ins, input logic z, input int dly);
        int   t;
        exp_t e;
        t = 0;
        while (!imem_req && t < 20) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = $urandom;
            @(negedge clock);
            t++;
        end
        imem_ack = 1'b0;
        if (!imem_req) begin
            chk("req_timeout", 64'(imem_req), 64'd1);
            abort = 1;
            return;
        end
        chk("fetch_addr", imem_addr, mpc);
        for (int i = 0; i < dly; i++) begin
            @(negedge clock);
            chk("wait_req_addr", {imem_req, imem_addr}, {1'b1, mpc});
        end
        e = model(ins, z, mpc);
        e.wb_cyc = cyc + 3;
        q.push_back(e);
        if (!e.halt) n_ret++;
        imem_ack  = 1'b1;
        imem_data = ins;
        zero      = z;
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = $urandom;
        mpc = e.npc;
    endtask

    // Monitor: a retired increment marks the previous cycle as WB.
    initial begin : monitor
        exp_t        e;
        bit          have_prev;
        logic        p_rw, p_jal, p_nop, p_src, p_halt;
        logic [1:0]  p_stk;
        logic [4:0]  p_rs, p_rt, p_rd;
        logic [3:0]  p_alu;
        logic [31:0] p_imm, p_pc, p_ret;
        int          p_cyc;
        have_prev = 0;
        forever begin
            @(negedge clock);
            if (run) begin
                if (have_prev) begin
                    if (retired == p_ret + 32'd1) begin
                        if (q.size() == 0) chk("unexpected_retire", 64'd1, 64'd0);
                        else begin
                            e = q.pop_front();
                            chk("retire_not_halt", 64'(e.halt), 64'd0);
                            chk("wb_cycle", 64'(p_cyc), 64'(e.wb_cyc));
                            chk("regs", {p_rs, p_rt, p_rd}, {e.ins[25:21], e.ins[20:16], e.ins[15:11]});
                            chk("imm", p_imm, {{16{e.ins[15]}}, e.ins[15:0]});
                            chk("nop", 64'(p_nop), 64'(e.nop));
                            chk("strobes", {p_rw, p_jal, p_stk}, {e.rw, e.jl, e.stk});
                            chk("pc", p_pc, e.npc);
                            if (e.chk_alu) chk("alu", {p_alu, p_src}, {e.alu, e.src});
                        end
                    end else begin
                        chk("retired_hold", retired, p_ret);
                        chk("no_strobe", {p_rw, p_jal, p_stk}, 4'd0);
                    end
                    if (halted && !p_halt) begin
                        if (q.size() == 0) chk("unexpected_halt", 64'd1, 64'd0);
                        else begin
                            e = q.pop_front();
                            chk("halt_op", 64'(e.halt), 64'd1);
                            chk("halt_cycle", 64'(cyc), 64'(e.wb_cyc - 1));
                            chk("halt_pc", pc, e.npc);
                        end
                    end
                    if (halted) chk("halt_no_req", 64'(imem_req), 64'd0);
                end
                p_rw = reg_write; p_jal = jal; p_stk = stack_op; p_nop = nop;
                p_src = alu_src_imm; p_alu = alu_op; p_rs = rs; p_rt = rt; p_rd = rd;
                p_imm = imm; p_pc = pc; p_ret = retired; p_halt = halted; p_cyc = cyc;
                have_prev = 1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] d_ins [8] = '{32'h00221820, 32'h20220005, 32'h1022FFFF, 32'h1022FFFF,
                               32'h0C000010, 32'hE0030000, 32'hE4040000, 32'hE8001234};
    logic        d_z   [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          d_dly [8] = '{0, 1, 0, 2, 0, 3, 3, 0};

    initial begin : driver
        int t;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1 chk("req_after_reset", 64'(imem_req), 64'd1);
        @(negedge clock);
        #2 reset = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hFFFF_FFFF;
        #1 chk("reset_drops_req", {imem_req, halted, reg_write}, 3'd0);
        repeat (2) @(negedge clock);
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        chk("reset_pc", {pc, imem_addr}, 64'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_ir", {rs, rt, rd, imm, nop}, {47'd0, 1'b1});
        run = 1;
        for (int i = 0; i < 8 && !abort; i++) fetch_one(d_ins[i], d_z[i], d_dly[i]);
        for (int i = 0; i < 150 && !abort; i++)
            fetch_one(rand_ins(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        if (!abort) fetch_one(32'hFC00_0000, 1'b0, 1);
        t = 0;
        while (!halted && t < 20) begin @(negedge clock); t++; end
        chk("halted_reached", 64'(halted), 64'd1);
        repeat (10) @(negedge clock);
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("retired_total", retired, 32'(n_ret));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
